// File: rtl/acs_if.sv
// Port bundle for the 8-state add-compare-select unit.
// Carries branch-metric inputs and survivor-memory write outputs.
interface acs_if #(
   parameter int ADDR_W = 6
);
   logic              enable;
   logic              in_valid;
   logic [1:0]        bm_00;
   logic [1:0]        bm_01;
   logic [1:0]        bm_10;
   logic [1:0]        bm_11;
   logic [7:0]        dec;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              bank_sel;
   logic              frame_done;
   logic [2:0]        best_state;

   modport master (
      output enable, in_valid,
      output bm_00, bm_01, bm_10, bm_11,
      input  dec, wr_en, wr_addr,
      input  bank_sel, frame_done, best_state
   );

   modport slave (
      input  enable, in_valid,
      input  bm_00, bm_01, bm_10, bm_11,
      output dec, wr_en, wr_addr,
      output bank_sel, frame_done, best_state
   );
endinterface

// File: rtl/acs_unit.sv
// 8-state Viterbi add-compare-select with saturating 7-bit metrics,
// modulo normalisation and double-banked survivor-memory addressing.
module acs_unit #(
   parameter int FRAME_LEN = 64,
   parameter int ADDR_W    = 6
) (
   input logic clk,
   input logic rst,
   acs_if.slave bus
);

   localparam logic [2:0] PRED_A [8] = '{
      3'd0, 3'd3, 3'd4, 3'd7, 3'd1, 3'd2, 3'd5, 3'd6
   };
   localparam logic [2:0] PRED_B [8] = '{
      3'd1, 3'd2, 3'd5, 3'd6, 3'd0, 3'd3, 3'd4, 3'd7
   };
   localparam logic [1:0] LAB_A [8] = '{
      2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00, 2'b10
   };
   localparam logic [1:0] LAB_B [8] = '{
      2'b11, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01
   };
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

   logic [6:0]        pm     [8];
   logic [6:0]        cand_a [8];
   logic [6:0]        cand_b [8];
   logic [6:0]        raw    [8];
   logic [6:0]        npm    [8];
   logic [1:0]        bm     [4];
   logic [7:0]        sel;
   logic              all_hi;
   logic [6:0]        mn;
   logic [2:0]        best;
   logic [ADDR_W-1:0] cnt;
   logic              bank;

   function automatic logic [6:0] sat_add(
      input logic [6:0] p,
      input logic [1:0] b
   );
      logic [7:0] s;
      s = {1'b0, p} + {6'd0, b};
      return s[7] ? 7'd127 : s[6:0];
   endfunction

   assign bm[0] = bus.bm_00;
   assign bm[1] = bus.bm_01;
   assign bm[2] = bus.bm_10;
   assign bm[3] = bus.bm_11;

   always_comb begin
      sel = '0;
      for (int s = 0; s < 8; s++) begin
         cand_a[s] = sat_add(pm[PRED_A[s]], bm[LAB_A[s]]);
         cand_b[s] = sat_add(pm[PRED_B[s]], bm[LAB_B[s]]);
         sel[s]    = cand_b[s] < cand_a[s];
         raw[s]    = sel[s] ? cand_b[s] : cand_a[s];
      end
   end

   // Clearing bit 6 on all metrics at once keeps differences intact.
   always_comb begin
      all_hi = 1'b1;
      for (int s = 0; s < 8; s++)
         all_hi = all_hi & raw[s][6];
      for (int s = 0; s < 8; s++)
         npm[s] = all_hi ? {1'b0, raw[s][5:0]} : raw[s];
   end

   always_comb begin
      mn   = npm[0];
      best = 3'd0;
      for (int s = 1; s < 8; s++) begin
         if (npm[s] < mn) begin
            mn   = npm[s];
            best = 3'(s);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < 8; s++)
            pm[s] <= (s == 0) ? 7'd0 : 7'd32;
         cnt            <= '0;
         bank           <= 1'b0;
         bus.dec        <= '0;
         bus.wr_en      <= 1'b0;
         bus.wr_addr    <= '0;
         bus.bank_sel   <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.best_state <= '0;
      end else if (!bus.enable) begin
         for (int s = 0; s < 8; s++)
            pm[s] <= (s == 0) ? 7'd0 : 7'd32;
         cnt            <= '0;
         bus.wr_en      <= 1'b0;
         bus.frame_done <= 1'b0;
      end else if (bus.in_valid) begin
         for (int s = 0; s < 8; s++)
            pm[s] <= npm[s];
         cnt            <= cnt + 1'b1;
         bus.dec        <= sel;
         bus.wr_en      <= 1'b1;
         bus.wr_addr    <= cnt;
         bus.bank_sel   <= bank;
         bus.frame_done <= (cnt == LAST);
         bus.best_state <= best;
         if (cnt == LAST)
            bank <= ~bank;
      end else begin
         bus.wr_en      <= 1'b0;
         bus.frame_done <= 1'b0;
      end
   end

endmodule

// File: doc/acs_unit.md
ACS_UNIT -- requirements
Module: acs_unit

Interface
REQ-001 Parameter: FRAME_LEN, 64, trellis steps per survivor-memory bank (power of two, 4..256).
REQ-002 Parameter: ADDR_W, 6, width of wr_addr, equal to log2(FRAME_LEN).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  run; low forces metric re-initialisation and frame restart.
REQ-006 in_valid  input  1  branch metrics valid this cycle; no back-pressure.
REQ-007 bm_00, bm_01, bm_10, bm_11  input  2 each  branch metric for codeword label 00/01/10/11, unsigned.
REQ-008 dec  output  8  survivor decision vector, bit s belongs to state s.
REQ-009 wr_en  output  1  dec/wr_addr/bank_sel valid, survivor-memory write strobe.
REQ-010 wr_addr  output  ADDR_W  trellis-step index within current bank.
REQ-011 bank_sel  output  1  survivor bank being written, toggles per frame.
REQ-012 frame_done  output  1  one-cycle pulse coincident with the last write of a frame.
REQ-013 best_state  output  3  index of minimum path metric after the latest update.

Function
REQ-014 Trellis, 8 states; state s has predecessors A (decision 0) and B (decision 1) with labels: s0 A=0/00 B=1/11; s1 A=3/10 B=2/01; s2 A=4/11 B=5/00; s3 A=7/01 B=6/10; s4 A=1/11 B=0/00; s5 A=2/10 B=3/01; s6 A=5/00 B=4/11; s7 A=6/10 B=7/01.
REQ-015 Path metrics: eight 7-bit unsigned registers pm[0..7].
REQ-016 Per accepted step (enable=1 and in_valid=1): candA = pm[A]+bm[labelA], candB = pm[B]+bm[labelB], computed 8-bit, saturated to 127.
REQ-017 Select: candB < candA -> decision 1, new pm = candB; otherwise (including tie) decision 0, new pm = candA.
REQ-018 Normalisation: if all eight selected metrics have bit 6 set, bit 6 cleared on all eight in the same update.
REQ-019 Metrics hold unchanged on cycles with in_valid=0.
REQ-020 Latency: one cycle; dec, wr_en, wr_addr, bank_sel, frame_done, best_state registered, valid the cycle after the accepted step.
REQ-021 wr_en = 1 exactly one cycle after each accepted step, else 0; dec holds last value when wr_en=0.
REQ-022 Step counter: wr_addr of an accepted step equals count of accepted steps since frame start, wrapping FRAME_LEN-1 -> 0.
REQ-023 Step with address FRAME_LEN-1: frame_done=1 with that write; bank_sel toggles for the next write.
REQ-024 best_state: lowest index among minimum new metrics (ties -> lower index).
REQ-025 enable=0: pm re-initialised (pm[0]=0, others=32), step counter to 0, bank_sel held, wr_en=0, no step accepted regardless of in_valid.
REQ-026 enable rising: first accepted step writes wr_addr=0 into the current bank_sel.

Reset
REQ-027 rst=1 immediately forces pm[0]=0, pm[1..7]=32, counter 0, bank_sel=0, dec=0, wr_en=0, wr_addr=0, frame_done=0, best_state=0.
REQ-028 rst asserted mid-frame discards the partial frame; first accepted step after release writes wr_addr=0, bank_sel=0.

Verification
REQ-029 Reset, enable=1, in_valid=1, bm_00=0 others 3, 8 steps -> each write dec[0]=0, best_state=0, pm[0] stays 0, wr_addr 0..7.
REQ-030 Tie: pm all equal (force via all bm=0 for 3 steps from init, then all bm=1) -> dec=8'h00 every write (tie selects A).
REQ-031 Constant bm=3 for all labels, 70 steps -> no metric exceeds 127, normalisation occurs, relative differences preserved across it.
REQ-032 FRAME_LEN=64, in_valid toggled every other cycle, 128 accepted steps -> wr_en only after accepted steps, frame_done at steps 63 and 127, bank_sel 0->1->0.
REQ-033 enable dropped at wr_addr=20 for 3 cycles with in_valid=1 -> no writes, next write wr_addr=0, same bank_sel, pm reinitialised.
REQ-034 rst pulsed asynchronously at wr_addr=40 in bank 1 -> outputs zero immediately, next write wr_addr=0, bank_sel=0.
